// File: rtl/osc_trace_capture_pkg.sv
// ---------------------------------------------------------------------------
// osc_trace_capture_pkg
// Shared definitions for the oscilloscope trace-capture stage: default sizes,
// the capture FSM state encoding and the trigger-crossing helper.
// No ports (package).
// ---------------------------------------------------------------------------
package osc_trace_capture_pkg;

   localparam int DATA_W           = 16;
   localparam int ADDR_W           = 10;
   localparam int DECIM_W          = 8;
   localparam int DEF_DEPTH        = 640;
   localparam int DEF_AUTO_TIMEOUT = 4096;

   typedef enum logic [1:0] {
      ST_ARMED   = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   // A crossing is judged between the previous decimated sample and the
   // current one, with the threshold itself counting as "reached".
   function automatic logic crossing(
      input logic signed [DATA_W-1:0] prevSample,
      input logic signed [DATA_W-1:0] curSample,
      input logic signed [DATA_W-1:0] level,
      input logic                     fallingSlope
   );
      logic hit;
      if (fallingSlope)
         hit = (prevSample > level) && (curSample <= level);
      else
         hit = (prevSample < level) && (curSample >= level);
      return hit;
   endfunction

endpackage

// File: rtl/osc_trace_capture_if.sv
// ---------------------------------------------------------------------------
// osc_trace_capture_if
// Bundles the generator/display side signals of the trace-capture stage.
//   master : generator + display side (drives sample, controls, rd_addr)
//   slave  : capture stage (drives rd_data and status flags)
// Signals: signal, decim, trig_level, trig_slope, auto_mode, frame_done,
//          rd_addr, rd_data, trace_valid, busy, auto_trig.
// ---------------------------------------------------------------------------
interface osc_trace_capture_if;
   import osc_trace_capture_pkg::*;

   logic [DATA_W-1:0]  signal;
   logic [DECIM_W-1:0] decim;
   logic [DATA_W-1:0]  trig_level;
   logic               trig_slope;
   logic               auto_mode;
   logic               frame_done;
   logic [ADDR_W-1:0]  rd_addr;
   logic [DATA_W-1:0]  rd_data;
   logic               trace_valid;
   logic               busy;
   logic               auto_trig;

   modport master (
      output signal, decim, trig_level, trig_slope, auto_mode, frame_done, rd_addr,
      input  rd_data, trace_valid, busy, auto_trig
   );

   modport slave (
      input  signal, decim, trig_level, trig_slope, auto_mode, frame_done, rd_addr,
      output rd_data, trace_valid, busy, auto_trig
   );

endinterface

// File: rtl/osc_trace_capture_ram.sv
// ---------------------------------------------------------------------------
// osc_trace_capture_ram
// Simple dual-port line buffer, DEPTH x DATA_W: one write port, one
// registered read port (1-cycle latency, read-before-write on collision).
// Ports:
//   clk, rst_n       clock / async active-low reset (read register only)
//   i_we, i_wrAddr, i_wrData   write port
//   i_rdAddr, o_rdData         read port
// ---------------------------------------------------------------------------
module osc_trace_capture_ram #(
   parameter int DEPTH  = 640,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_wrAddr,
   input  logic [DATA_W-1:0] i_wrData,
   input  logic [ADDR_W-1:0] i_rdAddr,
   output logic [DATA_W-1:0] o_rdData
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdData;

   // Storage array has no reset so it maps onto block RAM; old traces
   // survive a reset by design.
   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_wrAddr] <= i_wrData;
   end

   // Read register samples the array every cycle; because the write above is
   // non-blocking, a same-address collision returns the previous word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_rdData <= '0;
      else
         r_rdData <= r_mem[i_rdAddr];
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/osc_trace_capture.sv
// ---------------------------------------------------------------------------
// osc_trace_capture
// Triggered capture stage between the signal generator and the scope display.
// Decimates the incoming sample stream, waits for a level/slope trigger (or a
// timeout in auto mode), stores DEPTH decimated samples and holds them until
// the display signals a frame boundary, so the picture never tears.
// Ports:
//   CLOCK_50  system clock (rising edge)
//   RESET_n   asynchronous active-low reset
//   bus       osc_trace_capture_if.slave (sample, controls, read port, flags)
// ---------------------------------------------------------------------------
module osc_trace_capture
   import osc_trace_capture_pkg::*;
#(
   parameter int DEPTH        = DEF_DEPTH,
   parameter int AUTO_TIMEOUT = DEF_AUTO_TIMEOUT
) (
   input  logic                CLOCK_50,
   input  logic                RESET_n,
   osc_trace_capture_if.slave  bus
);

   localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(AUTO_TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

   state_t                    r_state;
   logic [DECIM_W-1:0]        r_decCnt;
   logic signed [DATA_W-1:0]  r_prev;
   logic [TMO_W-1:0]          r_tmoCnt;
   logic [ADDR_W-1:0]         r_wrAddr;
   logic                      r_busy;
   logic                      r_traceValid;
   logic                      r_autoTrig;

   logic [DECIM_W-1:0]        w_decMax;
   logic                      w_tick;
   logic                      w_cross;
   logic                      w_timeout;
   logic                      w_fire;
   logic                      w_we;
   logic [ADDR_W-1:0]         w_wrAddr;

   // Decimation ratio 0 behaves like 1. Comparing with >= lets a ratio that
   // is lowered mid-count still wrap promptly instead of running to overflow.
   assign w_decMax  = (bus.decim == '0) ? '0 : (bus.decim - DECIM_W'(1));
   assign w_tick    = (r_decCnt >= w_decMax);
   assign w_cross   = crossing(r_prev, bus.signal, bus.trig_level, bus.trig_slope);
   assign w_timeout = bus.auto_mode && (r_tmoCnt == TMO_LAST);

   // The trigger sample itself is the first word of the trace, so the write
   // port is enabled on the firing tick in ARMED and on every CAPTURE tick.
   assign w_fire    = (r_state == ST_ARMED) && w_tick && (w_cross || w_timeout);
   assign w_we      = w_fire || ((r_state == ST_CAPTURE) && w_tick);
   assign w_wrAddr  = (r_state == ST_ARMED) ? '0 : r_wrAddr;

   // Decimator: free-running counter producing one tick per kept sample, and
   // the previous-sample register used by the crossing detector.
   always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
      if (!RESET_n) begin
         r_decCnt <= '0;
         r_prev   <= '0;
      end else if (w_tick) begin
         r_decCnt <= '0;
         r_prev   <= bus.signal;
      end else begin
         r_decCnt <= r_decCnt + DECIM_W'(1);
      end
   end

   // Capture FSM with registered status flags. ARMED counts ticks toward the
   // auto-trigger (saturating when auto mode is off), CAPTURE fills the
   // buffer, HOLD freezes it until the display reports a frame boundary.
   always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
      if (!RESET_n) begin
         r_state      <= ST_ARMED;
         r_tmoCnt     <= '0;
         r_wrAddr     <= '0;
         r_busy       <= 1'b0;
         r_traceValid <= 1'b0;
         r_autoTrig   <= 1'b0;
      end else begin
         case (r_state)
            ST_ARMED: begin
               r_traceValid <= 1'b0;
               if (w_tick) begin
                  if (w_cross || w_timeout) begin
                     r_state    <= ST_CAPTURE;
                     r_wrAddr   <= ADDR_W'(1);
                     r_tmoCnt   <= '0;
                     r_busy     <= 1'b1;
                     r_autoTrig <= !w_cross;
                  end else if (r_tmoCnt != TMO_LAST) begin
                     r_tmoCnt <= r_tmoCnt + TMO_W'(1);
                  end
               end
            end
            ST_CAPTURE: begin
               if (w_tick) begin
                  r_wrAddr <= r_wrAddr + ADDR_W'(1);
                  if (r_wrAddr == ADDR_LAST) begin
                     r_state <= ST_HOLD;
                     r_busy  <= 1'b0;
                  end
               end
            end
            ST_HOLD: begin
               if (bus.frame_done) begin
                  r_state      <= ST_ARMED;
                  r_traceValid <= 1'b0;
                  r_tmoCnt     <= '0;
                  r_wrAddr     <= '0;
               end else begin
                  r_traceValid <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_ARMED;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   osc_trace_capture_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk      (CLOCK_50),
      .rst_n    (RESET_n),
      .i_we     (w_we),
      .i_wrAddr (w_wrAddr),
      .i_wrData (bus.signal),
      .i_rdAddr (bus.rd_addr),
      .o_rdData (bus.rd_data)
   );

   assign bus.busy        = r_busy;
   assign bus.trace_valid = r_traceValid;
   assign bus.auto_trig   = r_autoTrig;

endmodule

// File: tb/tb_osc_trace_capture.sv
// ---------------------------------------------------------------------------
// tb_osc_trace_capture
// Directed bench for osc_trace_capture: rising/falling triggers, decimation,
// auto trigger, frame handshake, read latency and mid-capture reset.
// ---------------------------------------------------------------------------
module tb_osc_trace_capture;
   import osc_trace_capture_pkg::*;

   logic CLOCK_50 = 1'b0;
   logic RESET_n;
   int   checks = 0;
   int   errors = 0;
   int   step   = 0;

   osc_trace_capture_if bus();

   osc_trace_capture dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_n  (RESET_n),
      .bus      (bus)
   );

   // 50 MHz clock
   always #10 CLOCK_50 = ~CLOCK_50;

   // Hard time limit so a stuck design still terminates.
   initial begin
      #5ms;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance n clocks; inputs change 1 ns after each rising edge and the
   // generator ramp moves by 'step' per cycle.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
         bus.signal = bus.signal + 16'(step);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkWord(input string tag, input int addr, input logic [15:0] exp);
      bus.rd_addr = ADDR_W'(addr);
      applyStimulus(1);
      checkOutput(tag, 32'(bus.rd_data), 32'(exp));
   endtask

   task automatic doReset();
      RESET_n = 1'b0;
      applyStimulus(2);
      RESET_n = 1'b1;
   endtask

   task automatic waitBusy(input int limit);
      for (int i = 0; i < limit; i++) begin
         if (bus.busy) break;
         applyStimulus(1);
      end
   endtask

   initial begin
      int bad;
      RESET_n        = 1'b0;
      bus.signal     = '0;
      bus.decim      = 8'd1;
      bus.trig_level = '0;
      bus.trig_slope = 1'b0;
      bus.auto_mode  = 1'b0;
      bus.frame_done = 1'b0;
      bus.rd_addr    = '0;

      // Reset state
      #5;
      checkOutput("rst_busy",   32'(bus.busy),        32'd0);
      checkOutput("rst_valid",  32'(bus.trace_valid), 32'd0);
      checkOutput("rst_auto",   32'(bus.auto_trig),   32'd0);
      checkOutput("rst_rddata", 32'(bus.rd_data),     32'd0);
      applyStimulus(2);
      RESET_n = 1'b1;

      // Rising trigger on a +1 ramp through 0: trace holds 0..639
      bus.signal = 16'(-100);
      step = 1;
      waitBusy(2000);
      checkOutput("t1_trig",     32'(bus.busy),      32'd1);
      checkOutput("t1_autoTrig", 32'(bus.auto_trig), 32'd0);
      applyStimulus(638);
      checkOutput("t1_busyLate",  32'(bus.busy),        32'd1);
      checkOutput("t1_validLate", 32'(bus.trace_valid), 32'd0);
      applyStimulus(1);
      checkOutput("t1_busyEnd",   32'(bus.busy),        32'd0);
      checkOutput("t1_validEnd",  32'(bus.trace_valid), 32'd0);
      applyStimulus(1);
      checkOutput("t1_validRise", 32'(bus.trace_valid), 32'd1);

      // Read latency: address change shows up one edge later
      bus.rd_addr = 10'd10;
      applyStimulus(1);
      checkOutput("t5_rd10", 32'(bus.rd_data), 32'd10);
      bus.rd_addr = 10'd11;
      applyStimulus(1);
      checkOutput("t5_rd11", 32'(bus.rd_data), 32'd11);
      for (int k = 0; k < 640; k++) checkWord("t1_word", k, 16'(k));

      // Frame handshake: trace frozen while frame_done stays low
      bad = 0;
      for (int i = 0; i < 5000; i++) begin
         applyStimulus(1);
         if (bus.trace_valid !== 1'b1 || bus.busy !== 1'b0) bad++;
      end
      checkOutput("t4_holdStable", 32'(bad), 32'd0);
      checkWord("t4_word5",   5,   16'd5);
      checkWord("t4_word639", 639, 16'd639);
      bus.frame_done = 1'b1;
      applyStimulus(1);
      bus.frame_done = 1'b0;
      checkOutput("t4_rearmValid", 32'(bus.trace_valid), 32'd0);
      checkOutput("t4_rearmBusy",  32'(bus.busy),        32'd0);

      // Auto trigger: constant 7 below level 100, fires on the 4096th tick
      step = 0;
      bus.signal     = 16'd7;
      bus.trig_level = 16'd100;
      bus.auto_mode  = 1'b1;
      doReset();
      applyStimulus(4095);
      checkOutput("t3_noEarly", 32'(bus.busy), 32'd0);
      applyStimulus(1);
      checkOutput("t3_fire",    32'(bus.busy),      32'd1);
      checkOutput("t3_autoTrg", 32'(bus.auto_trig), 32'd1);
      applyStimulus(639);
      checkOutput("t3_busyEnd", 32'(bus.busy), 32'd0);
      applyStimulus(1);
      checkOutput("t3_valid",   32'(bus.trace_valid), 32'd1);
      for (int k = 0; k < 640; k++) checkWord("t3_word", k, 16'd7);

      // Auto mode off: no capture at all
      bus.auto_mode = 1'b0;
      doReset();
      bad = 0;
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(1);
         if (bus.busy !== 1'b0) bad++;
      end
      checkOutput("t3_noAuto", 32'(bad), 32'd0);

      // Falling trigger with decim=4; ramp start aligned so ticks see
      // 1000, 996, ... and the crossing lands exactly on 500
      bus.decim      = 8'd4;
      bus.trig_level = 16'd500;
      bus.trig_slope = 1'b1;
      doReset();
      bus.signal = 16'd1003;
      step = -1;
      waitBusy(2000);
      checkOutput("t2_trig",     32'(bus.busy),      32'd1);
      checkOutput("t2_autoTrig", 32'(bus.auto_trig), 32'd0);
      applyStimulus(2555);
      checkOutput("t2_busyLate", 32'(bus.busy), 32'd1);
      applyStimulus(1);
      checkOutput("t2_busyEnd",  32'(bus.busy), 32'd0);
      applyStimulus(1);
      checkOutput("t2_valid",    32'(bus.trace_valid), 32'd1);
      for (int k = 0; k < 640; k++) checkWord("t2_word", k, 16'(500 - 4*k));

      // Mid-capture reset at wr_addr=300
      bus.decim      = 8'd1;
      bus.trig_level = 16'd0;
      bus.trig_slope = 1'b0;
      doReset();
      bus.signal  = 16'(-100);
      step        = 1;
      bus.rd_addr = 10'd5;
      waitBusy(2000);
      applyStimulus(299);
      checkOutput("t6_busyPre", 32'(bus.busy),    32'd1);
      checkOutput("t6_rdPre",   32'(bus.rd_data), 32'd5);
      RESET_n = 1'b0;
      #1;
      checkOutput("t6_busyAsync",  32'(bus.busy),        32'd0);
      checkOutput("t6_validAsync", 32'(bus.trace_valid), 32'd0);
      checkOutput("t6_rdAsync",    32'(bus.rd_data),     32'd0);
      applyStimulus(1);
      RESET_n = 1'b1;
      bus.trig_level = 16'd1000;
      bus.signal     = 16'd900;
      checkWord("t6_partial299", 299, 16'd299);
      checkWord("t6_old300",     300, 16'(500 - 1200));
      waitBusy(500);
      checkOutput("t6_retrig",   32'(bus.busy),      32'd1);
      checkOutput("t6_autoTrig", 32'(bus.auto_trig), 32'd0);
      checkWord("t6_fresh0", 0, 16'd1000);
      checkWord("t6_fresh1", 1, 16'd1001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
